// File: rtl/data_ram_arbiter_pkg.sv
// Shared constants for the data RAM arbiter: port ids, FSM states, lock bound.
package data_ram_arbiter_pkg;

    localparam int unsigned PORT_P       = 0;
    localparam int unsigned PORT_H       = 1;
    localparam int unsigned LOCK_MAX_DEF = 8;

    typedef enum logic {
        ARB   = 1'b0,
        HLOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/data_ram_arbiter_rr_arb2.sv
// Two-way round-robin grant; the port that did not win the last contended grant wins the next one.
module rr_arb2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_p,
    input  logic i_req_h,
    input  logic i_force_h,
    output logic o_gnt_p,
    output logic o_gnt_h
);

    logic r_last_h;
    logic w_both;

    assign w_both  = i_req_p && i_req_h;
    assign o_gnt_p = i_req_p && (!i_req_h || r_last_h);
    assign o_gnt_h = i_req_h && !o_gnt_p;

    // i_force_h marks H as last winner so P takes the first conflict after a lock
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_h <= 1'b1;
        end else if (i_force_h) begin
            r_last_h <= 1'b1;
        end else if (w_both) begin
            r_last_h <= o_gnt_h;
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Shares the single-port data RAM between core port P and host port H, with a bounded host lock.
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_valid,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_ready,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              h_valid,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_ready,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    input  logic              h_lock,
    output logic              h_lock_lost,
    output logic              ram_re,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_lock_cnt;
    logic             r_relock_blk;
    logic             r_rd_pend;
    logic             r_rd_tag;

    logic w_req_p;
    logic w_req_h;
    logic w_gnt_p;
    logic w_gnt_h;
    logic w_lock_enter;
    logic w_lost;

    assign w_req_p = p_valid && !rst && (r_state == ARB);
    assign w_req_h = h_valid && !rst;

    assign w_lock_enter = (r_state == ARB) && h_lock && w_gnt_h && !r_relock_blk;
    assign w_lost       = !rst && (r_state == HLOCK) && h_lock
                          && (r_lock_cnt == CNT_W'(LOCK_MAX - 1));

    rr_arb2 u_rr_arb2 (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req_p   (w_req_p),
        .i_req_h   (w_req_h),
        .i_force_h (w_lock_enter),
        .o_gnt_p   (w_gnt_p),
        .o_gnt_h   (w_gnt_h)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ARB;
            r_lock_cnt   <= '0;
            r_relock_blk <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_rd_tag     <= 1'b0;
        end else begin
            r_rd_pend <= (w_gnt_p && !p_we) || (w_gnt_h && !h_we);
            r_rd_tag  <= w_gnt_h ? 1'(PORT_H) : 1'(PORT_P);

            case (r_state)
                ARB: begin
                    if (w_lock_enter) begin
                        r_state    <= HLOCK;
                        r_lock_cnt <= '0;
                    end
                end
                HLOCK: begin
                    if (!h_lock) begin
                        r_state <= ARB;
                    end else if (w_lost) begin
                        r_state      <= ARB;
                        r_relock_blk <= 1'b1;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
                default: r_state <= ARB;
            endcase

            // a timed-out lock may only be re-taken after H drops h_lock
            if (!h_lock) begin
                r_relock_blk <= 1'b0;
            end
        end
    end

    always_comb begin
        ram_re   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (w_gnt_p) begin
            ram_re   = !p_we;
            ram_we   = p_we;
            ram_addr = p_addr;
            ram_din  = p_wdata;
        end else if (w_gnt_h) begin
            ram_re   = !h_we;
            ram_we   = h_we;
            ram_addr = h_addr;
            ram_din  = h_wdata;
        end
    end

    assign p_ready     = w_gnt_p;
    assign h_ready     = w_gnt_h;
    assign h_lock_lost = w_lost;

    assign p_rvalid = !rst && r_rd_pend && (r_rd_tag == 1'(PORT_P));
    assign h_rvalid = !rst && r_rd_pend && (r_rd_tag == 1'(PORT_H));
    assign p_rdata  = p_rvalid ? ram_dout : '0;
    assign h_rdata  = h_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Randomized bench for data_ram_arbiter against a rule-level reference model and a behavioural RAM.
module tb_data_ram_arbiter;

    localparam int unsigned AW   = 7;
    localparam int unsigned DW   = 16;
    localparam int unsigned LMAX = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p_valid = 1'b0, p_we = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_wdata = '0;
    logic          p_ready, p_rvalid;
    logic [DW-1:0] p_rdata;
    logic          h_valid = 1'b0, h_we = 1'b0, h_lock = 1'b0;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_wdata = '0;
    logic          h_ready, h_rvalid, h_lock_lost;
    logic [DW-1:0] h_rdata;
    logic          ram_re, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    logic [DW-1:0] mem    [128];
    logic [DW-1:0] shadow [128];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // reference model state
    bit          m_locked = 0;
    int unsigned m_cnt    = 0;
    bit          m_last_h = 1;
    bit          m_block  = 0;
    bit          m_pend   = 0;
    bit          m_pend_h = 0;
    logic [DW-1:0] m_pend_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_addr];
    end

    data_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LMAX)) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_ready(p_ready), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .h_valid(h_valid), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_ready(h_ready), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .h_lock(h_lock), .h_lock_lost(h_lock_lost),
        .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic step(input bit rs, input bit pv, input bit pwe, input logic [AW-1:0] pa,
                        input logic [DW-1:0] pd, input bit hv, input bit hwe,
                        input logic [AW-1:0] ha, input logic [DW-1:0] hd, input bit hl);
        bit gp, gh, lost, e_re, e_we, e_prv, e_hrv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        @(negedge clk);
        rst = rs; p_valid = pv; p_we = pwe; p_addr = pa; p_wdata = pd;
        h_valid = hv; h_we = hwe; h_addr = ha; h_wdata = hd; h_lock = hl;
        #1;
        gp = 0; gh = 0; lost = 0;
        if (!rs) begin
            if (m_locked) gh = hv;
            else if (pv && hv) begin gp = !m_last_h; gh = m_last_h; gp = m_last_h; gh = !m_last_h; end
            else begin gp = pv; gh = hv; end
            lost = m_locked && hl && (m_cnt == LMAX - 1);
        end
        e_re = 0; e_we = 0; e_addr = '0; e_din = '0;
        if (gp) begin e_re = !pwe; e_we = pwe; e_addr = pa; e_din = pd; end
        if (gh) begin e_re = !hwe; e_we = hwe; e_addr = ha; e_din = hd; end
        e_prv = !rs && m_pend && !m_pend_h;
        e_hrv = !rs && m_pend && m_pend_h;

        check("p_ready", 32'(p_ready), 32'(gp));
        check("h_ready", 32'(h_ready), 32'(gh));
        check("ram_re", 32'(ram_re), 32'(e_re));
        check("ram_we", 32'(ram_we), 32'(e_we));
        check("ram_addr", 32'(ram_addr), 32'(e_addr));
        check("ram_din", 32'(ram_din), 32'(e_din));
        check("p_rvalid", 32'(p_rvalid), 32'(e_prv));
        check("h_rvalid", 32'(h_rvalid), 32'(e_hrv));
        check("p_rdata", 32'(p_rdata), e_prv ? 32'(m_pend_data) : 32'd0);
        check("h_rdata", 32'(h_rdata), e_hrv ? 32'(m_pend_data) : 32'd0);
        check("h_lock_lost", 32'(h_lock_lost), 32'(lost));

        if (rs) begin
            m_locked = 0; m_cnt = 0; m_last_h = 1; m_block = 0; m_pend = 0;
        end else begin
            m_pend = 0;
            if (gp && !pwe) begin m_pend = 1; m_pend_h = 0; m_pend_data = shadow[pa]; end
            if (gh && !hwe) begin m_pend = 1; m_pend_h = 1; m_pend_data = shadow[ha]; end
            if (gp && pwe) shadow[pa] = pd;
            if (gh && hwe) shadow[ha] = hd;
            if (!m_locked) begin
                if (pv && hv) m_last_h = gh;
                if (hl && gh && !m_block) begin m_locked = 1; m_cnt = 0; m_last_h = 1; end
            end else if (!hl) begin
                m_locked = 0;
            end else if (lost) begin
                m_locked = 0; m_block = 1;
            end else begin
                m_cnt++;
            end
            if (!hl) m_block = 0;
        end
    endtask

    initial begin
        bit hl_r;
        for (int i = 0; i < 128; i++) begin
            mem[i]    = 16'($urandom);
            shadow[i] = mem[i];
        end

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // P write then read back, idle to see the read data
        step(0, 1, 1, 7'd5, 16'h1234, 0, 0, 0, 0, 0);
        step(0, 1, 0, 7'd5, 16'h0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // contention with alternating reads
        for (int i = 0; i < 6; i++) step(0, 1, 0, 7'd1, 0, 1, 0, 7'd2, 0, 0);
        // read granted then reset: pending read data must be dropped
        step(0, 1, 0, 7'd5, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 7'd5, 0, 1, 0, 7'd2, 0, 0);
        step(0, 1, 0, 7'd1, 0, 1, 0, 7'd2, 0, 0);
        // H write+lock, lock held past timeout while P waits
        step(0, 1, 0, 7'd9, 0, 1, 1, 7'd9, 16'h00FF, 1);
        for (int i = 0; i < 13; i++) step(0, 1, 0, 7'd3, 0, 1, 0, 7'd9, 0, 1);
        step(0, 1, 0, 7'd3, 0, 1, 0, 7'd9, 0, 0);
        step(0, 1, 0, 7'd3, 0, 1, 0, 7'd9, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 7'd3, 0, 1, 0, 7'd9, 0, 1);
        step(0, 1, 0, 7'd3, 0, 1, 0, 7'd9, 0, 0);
        step(0, 1, 0, 7'd3, 0, 1, 0, 7'd9, 0, 0);

        hl_r = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) hl_r = !hl_r;
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 9) < 7, 1'($urandom), 7'($urandom_range(0, 15)), 16'($urandom),
                 $urandom_range(0, 9) < 7, 1'($urandom), 7'($urandom_range(0, 15)), 16'($urandom),
                 hl_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Shares the single-port 16x128 data RAM between the processor core (port P) and a host/debug loader (port H). Grants one access per cycle with round-robin arbitration on conflict, drives the RAM strobes, and routes the 1-cycle-latency read data back to whichever port issued the read. Supports a bounded host lock for atomic read-modify-write sequences. Sits between the core's data-RAM outputs and the data RAM instance.

## Interface
- ADDR_W, 7, RAM address width (128 words)
- DATA_W, 16, RAM data width
- LOCK_MAX, 8, maximum consecutive cycles H may hold a lock before it is forcibly released

- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous active-high (one clock; reset is synchronous and active-high)
- p_valid  in  1  P requests an access this cycle
- p_we  in  1  1 = write, 0 = read
- p_addr  in  ADDR_W  P address
- p_wdata  in  DATA_W  P write data
- p_ready  out  1  P access accepted this cycle
- p_rvalid  out  1  P read data valid
- p_rdata  out  DATA_W  P read data
- h_valid, h_we, h_addr, h_wdata, h_ready, h_rvalid, h_rdata: same as P, for port H
- h_lock  in  1  H requests exclusive ownership
- h_lock_lost  out  1  one-cycle pulse: lock forcibly released by timeout
- ram_re  out  1  RAM read strobe
- ram_we  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data, valid one cycle after ram_re

## Operation
- States: ARB (round-robin), HLOCK (H exclusive).
- ARB: only one valid -> that port granted. Both valid -> port not granted last time wins; last_winner updates only on a contended grant.
- Granted port: ready=1 combinationally; ram_re = ~we, ram_we = we, addr/din muxed from that port. No grant -> ram_re=ram_we=0, addr/din=0.
- A read grant records rd_tag (port id) and rd_pend for one cycle; next cycle the tagged port gets rvalid=1, rdata=ram_dout. Other port's rdata=0, rvalid=0.
- ARB -> HLOCK when h_lock=1 and H is granted that cycle (lock takes effect from the next cycle). HLOCK: P never granted; H granted whenever h_valid.
- HLOCK -> ARB when h_lock=0, or lock counter reaches LOCK_MAX (pulse h_lock_lost; H must drop h_lock before re-locking—lock re-acquire blocked while h_lock stays high after a loss).
- Lock counter: counts cycles in HLOCK, cleared on entry; width clog2(LOCK_MAX+1).
- Write-to-read same address on consecutive cycles returns the new data (RAM write-first is not relied on; sequential accesses are ordered by grant).

## Timing
- Reset values: state=ARB, last_winner=H (P wins first conflict), rd_pend=0, lock counter=0, all outputs 0.
- Grant latency 0 (same cycle as valid); read latency 1 cycle from ready.
- Max throughput one access per cycle total; back-to-back reads from alternating ports return data in grant order.
- Under continuous contention in ARB, each port is granted every 2nd cycle; neither starves.
- P wait bounded by LOCK_MAX+1 cycles while H locks.
- rst mid-read: pending rvalid is dropped, no rvalid after reset.
- rst during HLOCK: returns to ARB, no h_lock_lost pulse.

## Structure
- Shared package: port-id constants (PORT_P=0, PORT_H=1), state encoding (ARB, HLOCK), LOCK_MAX default.
- One sub-module natural: rr_arb2 (2-way round-robin grant with last_winner register); rest is flat in data_ram_arbiter.

## Test plan
- Reset, P write 0x1234 to addr 5 alone, then P read addr 5 -> p_ready same cycle, p_rvalid next cycle with 0x1234; h_rvalid stays 0.
- Both valid every cycle, P reads addr 1, H reads addr 2 (preloaded 0xAAAA/0x5555) -> grants P,H,P,H...; each rvalid carries its own data, never cross-routed.
- H writes 0x00FF to addr 9 with h_lock=1 then reads addr 9 over 3 cycles while p_valid=1 -> p_ready=0 during lock; after h_lock drops P granted next cycle.
- H holds h_lock with LOCK_MAX=8 -> h_lock_lost pulses once at the 8th lock cycle, P granted next cycle; re-lock blocked until h_lock deasserted.
- P read granted, rst asserted next cycle -> no p_rvalid, all outputs 0, first post-reset conflict granted to P.
- Neither valid -> ram_re=ram_we=0, both ready=0, last_winner unchanged.
